tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS symbol decoder with word-alignment search.
// Decodes 10-bit TMDS symbols into control tokens or 8-bit pixel data and
// finds the deserializer word boundary. The boundary search counts
// consecutive control tokens to declare lock. It requests a one-bit bitslip
// when no control token has been seen for too long.
//
// Ports
//   clkin    in   pixel clock, rising edge
//   rst_n    in   asynchronous reset, asserted when high
//   din      in   [9:0] deserialized TMDS symbol, bit 0 first on the wire
//   din_vld  in   din holds a new symbol this cycle
//   dout     out  [7:0] decoded pixel byte (0 on control tokens)
//   c0, c1   out  decoded control bits (0 on data)
//   de       out  dout is active-video data
//   vld_out  out  qualifies dout/c0/c1/de; only while locked
//   bitslip  out  one-cycle request to shift the word boundary by one bit
//   locked   out  word boundary found
module tmds_decoder #(
   parameter int unsigned LOCK_CNT       = 8,
   parameter int unsigned SEARCH_TIMEOUT = 1024,
   parameter int unsigned SLIP_WAIT      = 16,
   parameter int unsigned MAX_ACTIVE     = 4095
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic [9:0] din,
   input  logic       din_vld,
   output logic [7:0] dout,
   output logic       c0,
   output logic       c1,
   output logic       de,
   output logic       vld_out,
   output logic       bitslip,
   output logic       locked
);

   localparam int unsigned CW = 12;
   localparam int unsigned TW = (LOCK_CNT  < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam int unsigned SW = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCKED = 2'd1,
      ST_SLIP   = 2'd2
   } state_t;

   state_t        state;
   logic [TW-1:0] tok_cnt;
   logic [CW-1:0] to_cnt;
   logic [CW-1:0] run_cnt;
   logic [SW-1:0] slip_cnt;

   // stage 1 registers
   logic [9:0]    din_q;
   logic          tok_q;
   logic [1:0]    ctl_q;
   logic          vld_q;

   logic          tok_c;
   logic [1:0]    ctl_c;
   logic [7:0]    d_c;
   logic [7:0]    data_c;
   logic          lose_c;

   // Control token match on the raw input symbol.
   always_comb begin
      tok_c = 1'b1;
      ctl_c = 2'b00;
      case (din)
         10'b1101010100: ctl_c = 2'b00;
         10'b0010101011: ctl_c = 2'b01;
         10'b0101010100: ctl_c = 2'b10;
         10'b1010101011: ctl_c = 2'b11;
         default:        tok_c = 1'b0;
      endcase
   end

   // Data decode of the stage-1 symbol: undo inversion, then undo XOR/XNOR chain.
   always_comb begin
      d_c    = din_q[9] ? ~din_q[7:0] : din_q[7:0];
      data_c = '0;
      data_c[0] = d_c[0];
      for (int i = 1; i < 8; i++) begin
         data_c[i] = din_q[8] ? (d_c[i] ^ d_c[i-1]) : ~(d_c[i] ^ d_c[i-1]);
      end
   end

   // Lock is lost on this edge: the data run exceeds the active-video limit.
   always_comb begin
      lose_c = (state == ST_LOCKED) && din_vld && !tok_c &&
               ((32'(run_cnt) + 32'd1) > MAX_ACTIVE);
   end

   // Stage 1: capture symbol, token flags and valid.
   always_ff @(posedge clkin or posedge rst_n) begin
      if (rst_n) begin
         din_q <= '0;
         tok_q <= 1'b0;
         ctl_q <= 2'b00;
         vld_q <= 1'b0;
      end else begin
         vld_q <= din_vld;
         if (din_vld) begin
            din_q <= din;
            tok_q <= tok_c;
            ctl_q <= ctl_c;
         end
      end
   end

   // Stage 2: decoded outputs. Symbols still in flight when lock drops are
   // suppressed by gating with the lock-loss condition.
   always_ff @(posedge clkin or posedge rst_n) begin
      if (rst_n) begin
         dout    <= '0;
         c0      <= 1'b0;
         c1      <= 1'b0;
         de      <= 1'b0;
         vld_out <= 1'b0;
      end else begin
         vld_out <= vld_q && locked && !lose_c;
         if (vld_q) begin
            if (tok_q) begin
               dout <= '0;
               c1   <= ctl_q[1];
               c0   <= ctl_q[0];
               de   <= 1'b0;
            end else begin
               dout <= data_c;
               c1   <= 1'b0;
               c0   <= 1'b0;
               de   <= 1'b1;
            end
         end
      end
   end

   // Alignment FSM: SEARCH -> LOCKED on enough tokens, SEARCH -> SLIP on
   // timeout, SLIP -> SEARCH after the settle wait, LOCKED -> SEARCH on
   // an over-long data run.
   always_ff @(posedge clkin or posedge rst_n) begin
      if (rst_n) begin
         state    <= ST_SEARCH;
         tok_cnt  <= '0;
         to_cnt   <= '0;
         run_cnt  <= '0;
         slip_cnt <= '0;
         bitslip  <= 1'b0;
         locked   <= 1'b0;
      end else begin
         bitslip <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (din_vld) begin
                  if (tok_c) begin
                     to_cnt <= '0;
                     if ((32'(tok_cnt) + 32'd1) >= LOCK_CNT) begin
                        state   <= ST_LOCKED;
                        locked  <= 1'b1;
                        tok_cnt <= '0;
                        run_cnt <= '0;
                     end else if (tok_cnt != '1) begin
                        tok_cnt <= tok_cnt + TW'(1);
                     end
                  end else begin
                     tok_cnt <= '0;
                     if ((32'(to_cnt) + 32'd1) >= SEARCH_TIMEOUT) begin
                        state    <= ST_SLIP;
                        bitslip  <= 1'b1;
                        to_cnt   <= '0;
                        slip_cnt <= '0;
                     end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + CW'(1);
                     end
                  end
               end
            end
            ST_SLIP: begin
               // din ignored; wait counts every cycle
               if ((32'(slip_cnt) + 32'd1) >= SLIP_WAIT) begin
                  state    <= ST_SEARCH;
                  slip_cnt <= '0;
               end else begin
                  slip_cnt <= slip_cnt + SW'(1);
               end
            end
            ST_LOCKED: begin
               if (din_vld) begin
                  if (tok_c) begin
                     run_cnt <= '0;
                  end else if (lose_c) begin
                     state   <= ST_SEARCH;
                     locked  <= 1'b0;
                     run_cnt <= '0;
                     tok_cnt <= '0;
                     to_cnt  <= '0;
                  end else if (run_cnt != '1) begin
                     run_cnt <= run_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state  <= ST_SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder.
module tb_tmds_decoder;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;

   logic       clkin;
   logic       rst_n;
   logic [9:0] din;
   logic       din_vld;
   logic [7:0] dout;
   logic       c0;
   logic       c1;
   logic       de;
   logic       vld_out;
   logic       bitslip;
   logic       locked;

   int n_pass  = 0;
   int n_total = 0;

   tmds_decoder dut (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .din     (din),
      .din_vld (din_vld),
      .dout    (dout),
      .c0      (c0),
      .c1      (c1),
      .de      (de),
      .vld_out (vld_out),
      .bitslip (bitslip),
      .locked  (locked)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic send(input logic [9:0] s);
      din     = s;
      din_vld = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      din     = '0;
      din_vld = 1'b0;
      repeat (n) tick();
   endtask

   logic [9:0]  vin [8];
   logic [10:0] vexp [8];   // {dout, c1, c0, de}
   logic        seen;

   initial begin
      vin[0] = 10'h100;  vexp[0] = {8'h00, 2'b00, 1'b1};
      vin[1] = 10'h200;  vexp[1] = {8'hFF, 2'b00, 1'b1};
      vin[2] = 10'h1FF;  vexp[2] = {8'h01, 2'b00, 1'b1};
      vin[3] = 10'h0F0;  vexp[3] = {8'hEE, 2'b00, 1'b1};
      vin[4] = 10'h2F0;  vexp[4] = {8'hEF, 2'b00, 1'b1};
      vin[5] = T01;      vexp[5] = {8'h00, 2'b01, 1'b0};
      vin[6] = T10;      vexp[6] = {8'h00, 2'b10, 1'b0};
      vin[7] = T11;      vexp[7] = {8'h00, 2'b11, 1'b0};

      rst_n   = 1'b0;
      din     = '0;
      din_vld = 1'b0;
      #2 rst_n = 1'b1;
      repeat (2) tick();
      chk("reset_outputs", 32'({dout, c1, c0, de, vld_out, bitslip, locked}), 32'h0);
      rst_n = 1'b0;
      tick();

      // acquire lock on 8 x T00
      for (int i = 0; i < 7; i++) send(T00);
      chk("lock_after_7", 32'(locked), 32'h0);
      send(T00);
      chk("lock_after_8", 32'(locked), 32'h1);
      idle(1);
      chk("tok8_vld", 32'(vld_out), 32'h1);
      chk("tok8_de", 32'(de), 32'h0);
      chk("tok8_ctl", 32'({c1, c0}), 32'h0);
      idle(1);
      chk("vld_drop_idle", 32'(vld_out), 32'h0);

      // back-to-back data while locked
      send(10'h100);
      send(10'h200);
      chk("b2b_first", 32'({dout, de, vld_out}), 32'({8'h00, 1'b1, 1'b1}));
      idle(1);
      chk("b2b_second", 32'({dout, de, vld_out}), 32'({8'hFF, 1'b1, 1'b1}));

      // decode table, last entry a token to clear the run counter
      for (int i = 0; i < 8; i++) begin
         send(vin[i]);
         idle(1);
         chk($sformatf("decode_%0d", i), 32'({dout, c1, c0, de}), 32'(vexp[i]));
         chk($sformatf("decode_vld_%0d", i), 32'(vld_out), 32'h1);
      end

      // over-long data run drops lock
      for (int i = 0; i < 4095; i++) send(10'h100);
      chk("run_4095_locked", 32'(locked), 32'h1);
      chk("run_4095_vld", 32'(vld_out), 32'h1);
      send(10'h100);
      chk("run_4096_unlocked", 32'(locked), 32'h0);
      chk("inflight_vld_a", 32'(vld_out), 32'h0);
      idle(1);
      chk("inflight_vld_b", 32'(vld_out), 32'h0);

      // interrupted token run restarts the count
      for (int i = 0; i < 4; i++) send(T00);
      send(10'h100);
      for (int i = 0; i < 7; i++) send(T00);
      chk("broken_run_unlocked", 32'(locked), 32'h0);
      send(T00);
      chk("broken_run_locked", 32'(locked), 32'h1);

      // asynchronous reset mid-cycle while locked
      rst_n = 1'b1;
      #1;
      chk("async_reset_locked", 32'({dout, c1, c0, de, vld_out, bitslip, locked}), 32'h0);
      tick();
      rst_n = 1'b0;

      // search timeout requests a single bitslip
      seen = 1'b0;
      for (int i = 0; i < 1023; i++) begin
         send(10'h100);
         seen = seen | bitslip;
      end
      chk("no_early_bitslip", 32'(seen), 32'h0);
      send(10'h100);
      chk("bitslip_pulse", 32'(bitslip), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(T00);
         seen = seen | bitslip;
      end
      chk("slip_no_second_pulse", 32'(seen), 32'h0);
      chk("slip_ignores_tokens", 32'(locked), 32'h0);
      for (int i = 0; i < 7; i++) send(T00);
      chk("post_slip_7", 32'(locked), 32'h0);
      send(T00);
      chk("post_slip_8", 32'(locked), 32'h1);

      // reset during SLIP aborts the wait
      rst_n = 1'b1;
      #1;
      tick();
      rst_n = 1'b0;
      for (int i = 0; i < 1024; i++) send(10'h1FF);
      chk("slip2_pulse", 32'(bitslip), 32'h1);
      chk("slip2_data", 32'({dout, de}), 32'({8'h01, 1'b1}));
      rst_n = 1'b1;
      #1;
      chk("reset_in_slip", 32'({dout, c1, c0, de, vld_out, bitslip, locked}), 32'h0);
      tick();
      rst_n = 1'b0;
      for (int i = 0; i < 7; i++) send(T00);
      chk("after_slip_reset_7", 32'(locked), 32'h0);
      send(T00);
      chk("after_slip_reset_8", 32'(locked), 32'h1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
